p405s_dsmmu_wr_1_of_32: RTL and testbench

//  Write-side companion of the MMU 1-of-32 region-bit selector. Holds two 32-bit region-control SPRs (spr1, spr2).

---
 rtl/p405s_dsmmu_wr_1_of_32.sv | 130 +++++++++++++
 tb/tb_p405s_dsmmu_wr_1_of_32.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_dsmmu_wr_1_of_32.sv
// Write side of the MMU 1-of-32 region-bit selector.
// Holds two region-control SPRs and updates them either by a full-word write
// or by setting/clearing one region bit addressed big-endian by ea[0:4].
// A request is captured in IDLE, waits in PEND while the pipeline is held,
// commits on the first unheld edge and is acknowledged for one cycle in ACK.
module p405s_dsmmu_wr_1_of_32 #(
  parameter logic [0:31] SPR1_RST = 32'h0000_0000,
  parameter logic [0:31] SPR2_RST = 32'h0000_0000
) (
  input  logic        CB,
  input  logic        resetCore,
  input  logic        wrReq,
  input  logic        wrMode,
  input  logic [0:1]  wrSel,
  input  logic [0:31] wrData,
  input  logic [0:4]  ea,
  input  logic        bitVal,
  input  logic        hold,
  output logic [0:31] spr1,
  output logic [0:31] spr2,
  output logic        busy,
  output logic        wrAck
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    ACK  = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        st_mode;
  logic [0:1]  st_sel;
  logic [0:31] st_data;
  logic [0:4]  st_ea;
  logic        st_bit;

  logic        capture;
  logic        commit;
  logic [0:31] spr1_nxt;
  logic [0:31] spr2_nxt;

  assign capture = (state_q == IDLE) && wrReq;
  assign commit  = (state_q == PEND) && !hold;

  // State register; reset drops any request in flight without acknowledging it
  always_ff @(posedge CB) begin
    if (resetCore) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; busy covers the whole PEND/ACK window
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    wrAck   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wrReq) begin
          state_d = PEND;
        end
      end
      PEND: begin
        busy = 1'b1;
        if (!hold) begin
          state_d = ACK;
        end
      end
      ACK: begin
        busy    = 1'b1;
        wrAck   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Staging registers freeze the request at capture so later input changes are ignored
  always_ff @(posedge CB) begin
    if (resetCore) begin
      st_mode <= 1'b0;
      st_sel  <= 2'b00;
      st_data <= 32'h0000_0000;
      st_ea   <= 5'b00000;
      st_bit  <= 1'b0;
    end else if (capture) begin
      st_mode <= wrMode;
      st_sel  <= wrSel;
      st_data <= wrData;
      st_ea   <= ea;
      st_bit  <= bitVal;
    end
  end

  // Candidate register values: whole word, or only the indexed bit (0 = MSB)
  always_comb begin
    spr1_nxt = spr1;
    spr2_nxt = spr2;
    if (st_mode) begin
      spr1_nxt[st_ea] = st_bit;
      spr2_nxt[st_ea] = st_bit;
    end else begin
      spr1_nxt = st_data;
      spr2_nxt = st_data;
    end
  end

  // Region registers update only on commit and only when selected
  always_ff @(posedge CB) begin
    if (resetCore) begin
      spr1 <= SPR1_RST;
      spr2 <= SPR2_RST;
    end else if (commit) begin
      if (st_sel[0]) begin
        spr1 <= spr1_nxt;
      end
      if (st_sel[1]) begin
        spr2 <= spr2_nxt;
      end
    end
  end

endmodule

// File: tb/tb_p405s_dsmmu_wr_1_of_32.sv
// Self-checking bench for the region-SPR write unit.
// Every request pushes the expected register pair onto a queue; a monitor
// pops and compares on each wrAck, while the scenario tasks check latency,
// busy, hold, reset and dropped-request behaviour inline.
module tb_p405s_dsmmu_wr_1_of_32;

  localparam logic [0:31] R1 = 32'hFFFF_0000;
  localparam logic [0:31] R2 = 32'h0000_0000;

  logic        CB;
  logic        resetCore;
  logic        wrReq;
  logic        wrMode;
  logic [0:1]  wrSel;
  logic [0:31] wrData;
  logic [0:4]  ea;
  logic        bitVal;
  logic        hold;
  logic [0:31] spr1;
  logic [0:31] spr2;
  logic        busy;
  logic        wrAck;

  typedef struct {
    logic [0:31] s1;
    logic [0:31] s2;
  } exp_t;

  exp_t        sb_q[$];
  logic [0:31] m_spr1;
  logic [0:31] m_spr2;
  int          vectors;
  int          miscompares;

  p405s_dsmmu_wr_1_of_32 #(
    .SPR1_RST(R1),
    .SPR2_RST(R2)
  ) dut (
    .CB        (CB),
    .resetCore (resetCore),
    .wrReq     (wrReq),
    .wrMode    (wrMode),
    .wrSel     (wrSel),
    .wrData    (wrData),
    .ea        (ea),
    .bitVal    (bitVal),
    .hold      (hold),
    .spr1      (spr1),
    .spr2      (spr2),
    .busy      (busy),
    .wrAck     (wrAck)
  );

  // Free-running clock
  initial CB = 1'b0;
  always #5 CB = ~CB;

  // Reference write semantics of one region register
  function automatic logic [0:31] model_wr(input logic [0:31] cur, input logic mode,
                                           input logic [0:31] data, input logic [0:4] idx,
                                           input logic bv);
    logic [0:31] r;
    r = cur;
    if (mode) r[idx] = bv;
    else      r = data;
    return r;
  endfunction

  // Scoreboard monitor: each acknowledge must match the oldest expected pair
  always @(negedge CB) begin
    if (wrAck === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL sb_unexpected_ack: wrAck=1 but no request outstanding");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (spr1 !== e.s1 || spr2 !== e.s2) begin
          miscompares++;
          $display("[TB] FAIL sb_ack_data: spr1=%h spr2=%h expected spr1=%h spr2=%h",
                   spr1, spr2, e.s1, e.s2);
        end
      end
    end
  end

  // Drive one request at the current negedge; returns one cycle later with it captured
  task automatic applyStimulus(input logic mode, input logic [0:1] sel, input logic [0:31] data,
                               input logic [0:4] idx, input logic bv);
    exp_t e;
    wrReq  = 1'b1;
    wrMode = mode;
    wrSel  = sel;
    wrData = data;
    ea     = idx;
    bitVal = bv;
    if (sel[0]) m_spr1 = model_wr(m_spr1, mode, data, idx, bv);
    if (sel[1]) m_spr2 = model_wr(m_spr2, mode, data, idx, bv);
    e.s1 = m_spr1;
    e.s2 = m_spr2;
    sb_q.push_back(e);
    @(negedge CB);
    wrReq = 1'b0;
  endtask

  // Bounded wait for the unit to return to idle
  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge CB);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: busy=%b expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    resetCore = 1'b1;
    repeat (3) @(negedge CB);
    resetCore = 1'b0;
    m_spr1 = R1;
    m_spr2 = R2;
    vectors++;
    if (spr1 !== 32'hFFFF_0000 || spr2 !== 32'h0000_0000 || busy !== 1'b0 || wrAck !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: spr1=%h spr2=%h busy=%b wrAck=%b expected FFFF0000 00000000 0 0",
               spr1, spr2, busy, wrAck);
    end
  endtask

  task automatic test_full_write;
    applyStimulus(1'b0, 2'b11, 32'hA5A5_1234, 5'd0, 1'b0);
    vectors++;
    if (busy !== 1'b1 || wrAck !== 1'b0 || spr1 !== R1 || spr2 !== R2) begin
      miscompares++;
      $display("[TB] FAIL full_pend: busy=%b wrAck=%b spr1=%h spr2=%h expected 1 0 %h %h",
               busy, wrAck, spr1, spr2, R1, R2);
    end
    @(negedge CB);
    vectors++;
    if (wrAck !== 1'b1 || busy !== 1'b1 || spr1 !== 32'hA5A5_1234 || spr2 !== 32'hA5A5_1234) begin
      miscompares++;
      $display("[TB] FAIL full_commit: wrAck=%b busy=%b spr1=%h spr2=%h expected 1 1 A5A51234 A5A51234",
               wrAck, busy, spr1, spr2);
    end
    @(negedge CB);
    vectors++;
    if (busy !== 1'b0 || wrAck !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_release: busy=%b wrAck=%b expected 0 0", busy, wrAck);
    end
  endtask

  task automatic test_bit_set;
    logic [0:31] s2_before;
    applyStimulus(1'b0, 2'b10, 32'h0000_0000, 5'd0, 1'b0);
    wait_idle("bitset_clear");
    s2_before = m_spr2;
    applyStimulus(1'b1, 2'b10, 32'hFFFF_FFFF, 5'b00111, 1'b1);
    @(negedge CB);
    vectors++;
    if (spr1 !== 32'h0100_0000 || spr2 !== s2_before) begin
      miscompares++;
      $display("[TB] FAIL bit_set: spr1=%h spr2=%h expected 01000000 %h", spr1, spr2, s2_before);
    end
    wait_idle("bitset");
  endtask

  task automatic test_bit_sweep;
    logic bv;
    logic [0:1] sel;
    applyStimulus(1'b0, 2'b01, 32'hFFFF_FFFF, 5'd0, 1'b0);
    wait_idle("sweep_fill");
    applyStimulus(1'b1, 2'b01, 32'h0000_0000, 5'b11111, 1'b0);
    @(negedge CB);
    vectors++;
    if (spr2 !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("[TB] FAIL bit_clear_31: spr2=%h expected FFFFFFFE", spr2);
    end
    wait_idle("bitclear");
    for (int i = 0; i < 32; i++) begin
      bv  = 1'($urandom_range(0, 1));
      sel = (i % 3 == 0) ? 2'b11 : ((i % 3 == 1) ? 2'b01 : 2'b10);
      applyStimulus(1'b1, sel, $urandom, 5'(i), bv);
      @(negedge CB);
      vectors++;
      if ((sel[1] && ~spr2[5'(i)] !== ~bv) || (sel[0] && ~spr1[5'(i)] !== ~bv)) begin
        miscompares++;
        $display("[TB] FAIL sweep_select ea=%0d: sel1=%b sel2=%b expected %b",
                 i, ~spr1[5'(i)], ~spr2[5'(i)], ~bv);
      end
      wait_idle("sweep");
    end
  endtask

  task automatic test_noop;
    logic [0:31] s1_before;
    logic [0:31] s2_before;
    s1_before = m_spr1;
    s2_before = m_spr2;
    applyStimulus(1'b0, 2'b00, 32'hDEAD_BEEF, 5'd3, 1'b1);
    @(negedge CB);
    vectors++;
    if (wrAck !== 1'b1 || spr1 !== s1_before || spr2 !== s2_before) begin
      miscompares++;
      $display("[TB] FAIL noop: wrAck=%b spr1=%h spr2=%h expected 1 %h %h",
               wrAck, spr1, spr2, s1_before, s2_before);
    end
    wait_idle("noop");
  endtask

  task automatic test_hold;
    logic [0:31] s1_before;
    logic [0:31] s2_before;
    s1_before = m_spr1;
    s2_before = m_spr2;
    hold = 1'b1;
    applyStimulus(1'b0, 2'b11, 32'h1357_9BDF, 5'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (busy !== 1'b1 || wrAck !== 1'b0 || spr1 !== s1_before || spr2 !== s2_before) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: busy=%b wrAck=%b spr1=%h spr2=%h expected 1 0 %h %h",
                 k, busy, wrAck, spr1, spr2, s1_before, s2_before);
      end
      wrData = ~wrData;
      @(negedge CB);
    end
    hold = 1'b0;
    vectors++;
    if (busy !== 1'b1 || spr1 !== s1_before) begin
      miscompares++;
      $display("[TB] FAIL hold_last: busy=%b spr1=%h expected 1 %h", busy, spr1, s1_before);
    end
    @(negedge CB);
    vectors++;
    if (wrAck !== 1'b1 || spr1 !== 32'h1357_9BDF || spr2 !== 32'h1357_9BDF) begin
      miscompares++;
      $display("[TB] FAIL hold_commit: wrAck=%b spr1=%h spr2=%h expected 1 13579BDF 13579BDF",
               wrAck, spr1, spr2);
    end
    wait_idle("hold");
  endtask

  task automatic test_reset_mid_pend;
    int acks;
    hold = 1'b1;
    applyStimulus(1'b0, 2'b11, 32'h1234_5678, 5'd0, 1'b0);
    wrReq  = 1'b1;
    wrData = 32'h8765_4321;
    @(negedge CB);
    resetCore = 1'b1;
    @(negedge CB);
    resetCore = 1'b0;
    wrReq     = 1'b0;
    hold      = 1'b0;
    sb_q.delete();
    m_spr1 = R1;
    m_spr2 = R2;
    vectors++;
    if (spr1 !== R1 || spr2 !== R2 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_state: spr1=%h spr2=%h busy=%b expected %h %h 0",
               spr1, spr2, busy, R1, R2);
    end
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      if (wrAck === 1'b1) acks++;
      @(negedge CB);
    end
    vectors++;
    if (acks != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ack: acks=%0d expected 0", acks);
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    applyStimulus(1'b0, 2'b11, 32'hCAFE_F00D, 5'd0, 1'b0);
    wrReq  = 1'b1;
    wrData = 32'h0BAD_0BAD;
    wrSel  = 2'b11;
    wrMode = 1'b0;
    acks   = 0;
    @(negedge CB);
    if (wrAck === 1'b1) acks++;
    @(negedge CB);
    wrReq = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (wrAck === 1'b1) acks++;
      @(negedge CB);
    end
    vectors++;
    if (acks != 1 || spr1 !== 32'hCAFE_F00D || spr2 !== 32'hCAFE_F00D || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: acks=%0d spr1=%h spr2=%h busy=%b expected 1 CAFEF00D CAFEF00D 0",
               acks, spr1, spr2, busy);
    end
  endtask

  // Scenario sequence and summary
  initial begin
    vectors     = 0;
    miscompares = 0;
    resetCore   = 1'b1;
    wrReq       = 1'b0;
    wrMode      = 1'b0;
    wrSel       = 2'b00;
    wrData      = 32'h0;
    ea          = 5'd0;
    bitVal      = 1'b0;
    hold        = 1'b0;
    m_spr1      = R1;
    m_spr2      = R2;
    test_reset();
    test_full_write();
    test_bit_set();
    test_bit_sweep();
    test_noop();
    test_hold();
    test_reset_mid_pend();
    test_back_to_back();
    repeat (2) @(negedge CB);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL sb_drain: %0d acknowledges missing, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
